// File: rtl/l2_cache_pkg.sv
// Shared types, derived widths and address field helpers for the L2 cache controller.
package l2_cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWriteBack,
        StAllocate,
        StRespond
    } l2_state_t;

    function automatic int unsigned calc_off_w(input int unsigned words_per_block);
        return $clog2(words_per_block);
    endfunction

    function automatic int unsigned calc_idx_w(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    // The top two address bits carry the processor ID and never reach the tag.
    function automatic int unsigned calc_tag_w(input int unsigned addr_width,
                                               input int unsigned words_per_block,
                                               input int unsigned num_lines);
        return addr_width - 2 - $clog2(words_per_block) - $clog2(num_lines);
    endfunction

    function automatic int unsigned calc_block_w(input int unsigned word_width,
                                                 input int unsigned words_per_block);
        return word_width * words_per_block;
    endfunction

    // Fields come back zero-extended; callers size-cast to the field width.
    function automatic logic [63:0] addr_index(input logic [63:0]  addr,
                                               input int unsigned  off_w,
                                               input int unsigned  idx_w);
        return (addr >> off_w) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0]  addr,
                                             input int unsigned  off_w,
                                             input int unsigned  idx_w,
                                             input int unsigned  tag_w);
        return (addr >> (off_w + idx_w)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/l2_cache_ctrl_if.sv
// L1-facing and memory-facing signal bundle of the L2 cache controller.
// slave: the controller; master: the L1 and memory side driving it.
interface l2_cache_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BLOCK_W    = 128
);
    logic                  l1_rd_req;
    logic                  l1_wb_req;
    logic [ADDR_WIDTH-1:0] l1_addr;
    logic [BLOCK_W-1:0]    l1_wb_data;
    logic [BLOCK_W-1:0]    l2_rd_data;
    logic                  l2_ready;
    logic                  l2_hit;
    logic                  l2_miss;
    logic                  mem_rd_req;
    logic                  mem_wr_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BLOCK_W-1:0]    mem_wr_data;
    logic [BLOCK_W-1:0]    mem_rd_data;
    logic                  mem_ack;

    modport slave (
        input  l1_rd_req, l1_wb_req, l1_addr, l1_wb_data, mem_rd_data, mem_ack,
        output l2_rd_data, l2_ready, l2_hit, l2_miss,
        output mem_rd_req, mem_wr_req, mem_addr, mem_wr_data
    );

    modport master (
        output l1_rd_req, l1_wb_req, l1_addr, l1_wb_data, mem_rd_data, mem_ack,
        input  l2_rd_data, l2_ready, l2_hit, l2_miss,
        input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_data
    );

endinterface

// File: rtl/l2_line_store.sv
// Tag/valid/dirty/data arrays of the L2 cache: asynchronous read and one synchronous
// write port, both addressed by the same line index.
module l2_line_store
    import l2_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 64,
    parameter int unsigned TAG_W     = 22,
    parameter int unsigned BLOCK_W   = 128,
    localparam int unsigned IDX_W    = calc_idx_w(NUM_LINES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IDX_W-1:0]   i_idx,
    output logic [TAG_W-1:0]   o_tag,
    output logic               o_valid,
    output logic               o_dirty,
    output logic [BLOCK_W-1:0] o_data,
    input  logic               i_wr_en,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [BLOCK_W-1:0] i_wr_data,
    input  logic               i_set_valid,
    input  logic               i_set_dirty,
    input  logic               i_clr_dirty
);
    logic [TAG_W-1:0]   r_tag  [NUM_LINES];
    logic [BLOCK_W-1:0] r_data [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    // Tags and data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_idx]  <= i_wr_tag;
            r_data[i_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_set_valid) begin
                r_valid[i_idx] <= 1'b1;
            end
            if (i_set_dirty) begin
                r_dirty[i_idx] <= 1'b1;
            end else if (i_clr_dirty) begin
                r_dirty[i_idx] <= 1'b0;
            end
        end
    end

    assign o_tag   = r_tag[i_idx];
    assign o_data  = r_data[i_idx];
    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];

endmodule

// File: rtl/l2_cache_ctrl.sv
// Direct-mapped write-back L2 cache controller between the L1 FSM and main memory.
// Define L2_CACHE_STATS_EN to add saturating stat_hits/stat_misses counters.
module l2_cache_ctrl
    import l2_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned WORD_WIDTH      = 32,
    parameter int unsigned WORDS_PER_BLOCK = 4,
    parameter int unsigned NUM_LINES       = 64
) (
    input  logic           clk,
    input  logic           reset,
    l2_cache_ctrl_if.slave bus
`ifdef L2_CACHE_STATS_EN
    ,
    output logic [31:0]    stat_hits,
    output logic [31:0]    stat_misses
`endif
);
    localparam int unsigned OFF_W   = calc_off_w(WORDS_PER_BLOCK);
    localparam int unsigned IDX_W   = calc_idx_w(NUM_LINES);
    localparam int unsigned TAG_W   = calc_tag_w(ADDR_WIDTH, WORDS_PER_BLOCK, NUM_LINES);
    localparam int unsigned BLOCK_W = calc_block_w(WORD_WIDTH, WORDS_PER_BLOCK);

    l2_state_t             r_state;
    l2_state_t             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_is_wb;
    logic [BLOCK_W-1:0]    r_wb_data;
    logic [BLOCK_W-1:0]    r_rd_data;
    logic                  r_missed;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [TAG_W-1:0]      w_line_tag;
    logic                  w_line_valid;
    logic                  w_line_dirty;
    logic [BLOCK_W-1:0]    w_line_data;
    logic                  w_tag_hit;
    logic                  w_victim_dirty;
    logic                  w_accept;

    logic                  w_st_wr_en;
    logic [BLOCK_W-1:0]    w_st_wr_data;
    logic                  w_st_set_valid;
    logic                  w_st_set_dirty;
    logic                  w_st_clr_dirty;

    assign w_idx          = IDX_W'(addr_index(64'(r_addr), OFF_W, IDX_W));
    assign w_tag          = TAG_W'(addr_tag(64'(r_addr), OFF_W, IDX_W, TAG_W));
    assign w_tag_hit      = w_line_valid && (w_line_tag == w_tag);
    assign w_victim_dirty = w_line_valid && w_line_dirty;
    assign w_accept       = (r_state == StIdle) && (bus.l1_wb_req || bus.l1_rd_req);

    l2_line_store #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W),
        .BLOCK_W   (BLOCK_W)
    ) u_line_store (
        .clk         (clk),
        .reset       (reset),
        .i_idx       (w_idx),
        .o_tag       (w_line_tag),
        .o_valid     (w_line_valid),
        .o_dirty     (w_line_dirty),
        .o_data      (w_line_data),
        .i_wr_en     (w_st_wr_en),
        .i_wr_tag    (w_tag),
        .i_wr_data   (w_st_wr_data),
        .i_set_valid (w_st_set_valid),
        .i_set_dirty (w_st_set_dirty),
        .i_clr_dirty (w_st_clr_dirty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (bus.l1_wb_req || bus.l1_rd_req) begin
                    w_state_nxt = StCompare;
                end
            end
            StCompare: begin
                if (w_tag_hit) begin
                    w_state_nxt = StRespond;
                end else if (w_victim_dirty) begin
                    w_state_nxt = StWriteBack;
                end else if (!r_is_wb) begin
                    w_state_nxt = StAllocate;
                end else begin
                    w_state_nxt = StRespond;
                end
            end
            StWriteBack: begin
                if (bus.mem_ack) begin
                    w_state_nxt = r_is_wb ? StCompare : StAllocate;
                end
            end
            StAllocate: begin
                if (bus.mem_ack) begin
                    w_state_nxt = StCompare;
                end
            end
            StRespond: w_state_nxt = StIdle;
            default:   w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        bus.l2_ready    = 1'b0;
        bus.l2_hit      = 1'b0;
        bus.l2_miss     = 1'b0;
        bus.mem_rd_req  = 1'b0;
        bus.mem_wr_req  = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        w_st_wr_en      = 1'b0;
        w_st_wr_data    = r_wb_data;
        w_st_set_valid  = 1'b0;
        w_st_set_dirty  = 1'b0;
        w_st_clr_dirty  = 1'b0;
        case (r_state)
            StCompare: begin
                bus.l2_hit  = w_tag_hit;
                bus.l2_miss = !w_tag_hit && !r_missed;
                // A write-back into a clean or empty line installs the block without a fetch.
                if (r_is_wb && (w_tag_hit || !w_victim_dirty)) begin
                    w_st_wr_en     = 1'b1;
                    w_st_set_valid = 1'b1;
                    w_st_set_dirty = 1'b1;
                end
            end
            StWriteBack: begin
                bus.mem_wr_req  = 1'b1;
                bus.mem_addr    = {2'b00, w_line_tag, w_idx, {OFF_W{1'b0}}};
                bus.mem_wr_data = w_line_data;
                w_st_clr_dirty  = bus.mem_ack;
            end
            StAllocate: begin
                bus.mem_rd_req = 1'b1;
                bus.mem_addr   = {2'b00, w_tag, w_idx, {OFF_W{1'b0}}};
                if (bus.mem_ack) begin
                    w_st_wr_en     = 1'b1;
                    w_st_wr_data   = bus.mem_rd_data;
                    w_st_set_valid = 1'b1;
                    w_st_clr_dirty = 1'b1;
                end
            end
            StRespond: bus.l2_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_is_wb   <= 1'b0;
            r_wb_data <= '0;
            r_rd_data <= '0;
            r_missed  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= bus.l1_addr;
                r_is_wb   <= bus.l1_wb_req;
                r_wb_data <= bus.l1_wb_data;
                r_missed  <= 1'b0;
            end
            if (r_state == StCompare) begin
                if (!w_tag_hit) begin
                    r_missed <= 1'b1;
                end else if (!r_is_wb) begin
                    r_rd_data <= w_line_data;
                end
            end
        end
    end

    assign bus.l2_rd_data = r_rd_data;

`ifdef L2_CACHE_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else begin
            if (bus.l2_hit && (r_stat_hits != 32'hFFFF_FFFF)) begin
                r_stat_hits <= r_stat_hits + 32'd1;
            end
            if (bus.l2_miss && (r_stat_misses != 32'hFFFF_FFFF)) begin
                r_stat_misses <= r_stat_misses + 32'd1;
            end
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Self-checking bench for l2_cache_ctrl: directed scenarios plus random traffic against a
// line-level cache model; the bench also plays the memory with random ack latency.
module tb_l2_cache_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 128;
    localparam int unsigned NL = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    l2_cache_ctrl_if #(.ADDR_WIDTH(AW), .BLOCK_W(BW)) bus_if ();

`ifdef L2_CACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    l2_cache_ctrl #(
        .ADDR_WIDTH      (AW),
        .WORD_WIDTH      (32),
        .WORDS_PER_BLOCK (4),
        .NUM_LINES       (NL)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if)
`ifdef L2_CACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_viol   = 0;
    int fixed_delay = -1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one entry per line plus a sparse main memory.
    bit              m_valid [NL];
    bit              m_dirty [NL];
    logic [21:0]     m_tag   [NL];
    logic [127:0]    m_data  [NL];
    logic [127:0]    ref_mem [logic [31:0]];
    logic [127:0]    dut_mem [logic [31:0]];
    int              exp_hits   = 0;
    int              exp_misses = 0;

    function automatic logic [127:0] mem_init(input logic [31:0] a);
        return {4{a ^ 32'hC0DE_0000}};
    endfunction

    function automatic logic [127:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_init(a);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    // Runs cycles until l2_ready, acting as memory; counts pulses and request cycles.
    task automatic run_until_ready(output int cyc, output int nh, output int nm, output int mc,
                                   output int nwr, output int nrd, output logic [31:0] wa,
                                   output logic [127:0] wd, output logic [31:0] ra,
                                   output bit tmo);
        int cnt;
        cnt = -1; cyc = 0; nh = 0; nm = 0; mc = 0; nwr = 0; nrd = 0;
        wa = '0; wd = '0; ra = '0; tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            bus_if.mem_ack = 1'b0;
            cyc++;
            if (bus_if.l2_hit) nh++;
            if (bus_if.l2_miss) nm++;
            if (bus_if.l2_hit && bus_if.l2_miss) n_viol++;
            if (bus_if.mem_rd_req && bus_if.mem_wr_req) n_viol++;
            if (bus_if.mem_rd_req || bus_if.mem_wr_req) begin
                mc++;
                if (cnt < 0) cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                if (cnt == 0) begin
                    bus_if.mem_ack = 1'b1;
                    if (bus_if.mem_wr_req) begin
                        nwr++;
                        wa = bus_if.mem_addr;
                        wd = bus_if.mem_wr_data;
                        dut_mem[bus_if.mem_addr] = bus_if.mem_wr_data;
                    end else begin
                        nrd++;
                        ra = bus_if.mem_addr;
                        bus_if.mem_rd_data = dut_mem.exists(bus_if.mem_addr) ?
                            dut_mem[bus_if.mem_addr] : mem_init(bus_if.mem_addr);
                    end
                    cnt = -1;
                end else begin
                    cnt--;
                end
            end
            if (bus_if.l2_ready) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    // Predicts one request from the model, runs it and compares; inputs are already driven.
    task automatic serve(input bit is_wb, input logic [31:0] addr, input logic [127:0] data,
                         input int extra, input string name);
        logic [31:0]  blk, exp_wa, wa, ra;
        logic [127:0] exp_wd, wd;
        logic [21:0]  tg;
        int           idx, e_hit, e_miss, cyc, nh, nm, mc, nwr, nrd;
        bit           hit, exp_wr, exp_rd, tmo;
        blk    = addr & 32'h3FFF_FFFC;
        idx    = int'((addr >> 2) & 32'h3F);
        tg     = 22'(addr >> 8);
        hit    = m_valid[idx] && (m_tag[idx] == tg);
        exp_wr = !hit && m_valid[idx] && m_dirty[idx];
        exp_rd = !hit && !is_wb;
        exp_wa = (32'(m_tag[idx]) << 8) | (32'(idx) << 2);
        exp_wd = m_data[idx];
        e_hit  = (hit || exp_rd) ? 1 : 0;
        e_miss = hit ? 0 : 1;
        if (exp_wr) ref_mem[exp_wa] = m_data[idx];
        if (is_wb) begin
            m_data[idx]  = data;
            m_dirty[idx] = 1'b1;
        end else if (!hit) begin
            m_data[idx]  = ref_read(blk);
            m_dirty[idx] = 1'b0;
        end
        m_tag[idx]   = tg;
        m_valid[idx] = 1'b1;
        exp_hits   += e_hit;
        exp_misses += e_miss;

        run_until_ready(cyc, nh, nm, mc, nwr, nrd, wa, wd, ra, tmo);
        check({name, "_timeout"}, 128'(tmo), 128'(0));
        check({name, "_latency"}, 128'(cyc), 128'(2 + ((mc > 0) ? mc + 1 : 0) + extra));
        check({name, "_hits"}, 128'(nh), 128'(e_hit));
        check({name, "_misses"}, 128'(nm), 128'(e_miss));
        check({name, "_nwr"}, 128'(nwr), 128'(exp_wr));
        check({name, "_nrd"}, 128'(nrd), 128'(exp_rd));
        if (exp_wr) begin
            check({name, "_wr_addr"}, 128'(wa), 128'(exp_wa));
            check({name, "_wr_data"}, wd, exp_wd);
        end
        if (exp_rd) check({name, "_rd_addr"}, 128'(ra), 128'(blk));
        if (!is_wb) check({name, "_rdata"}, bus_if.l2_rd_data, m_data[idx]);
    endtask

    task automatic do_txn(input bit is_wb, input logic [31:0] addr, input logic [127:0] data,
                          input string name);
        bus_if.l1_addr    = addr;
        bus_if.l1_wb_data = data;
        bus_if.l1_rd_req  = !is_wb;
        bus_if.l1_wb_req  = is_wb;
        serve(is_wb, addr, data, 0, name);
        bus_if.l1_rd_req = 1'b0;
        bus_if.l1_wb_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctl"}, 128'({bus_if.l2_ready, bus_if.l2_hit, bus_if.l2_miss,
                                    bus_if.mem_rd_req, bus_if.mem_wr_req, bus_if.mem_addr}),
              128'(0));
        check({name, "_rdata"}, bus_if.l2_rd_data, 128'(0));
        check({name, "_wdata"}, bus_if.mem_wr_data, 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0]  addr;
        logic [127:0] data;
        reset = 1'b1;
        bus_if.l1_rd_req   = 1'b0;
        bus_if.l1_wb_req   = 1'b0;
        bus_if.l1_addr     = '0;
        bus_if.l1_wb_data  = '0;
        bus_if.mem_rd_data = '0;
        bus_if.mem_ack     = 1'b0;
        model_reset();
        ref_mem[32'h10] = {4{32'hAAAA_AAAA}};
        dut_mem[32'h10] = {4{32'hAAAA_AAAA}};
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("idle");

        // Fill, then hit on the same block.
        fixed_delay = 3;
        do_txn(1'b0, 32'h0000_0010, '0, "t1_fill");
        fixed_delay = -1;
        do_txn(1'b0, 32'h0000_0010, '0, "t1_hit");

        // Dirty the line, then force its eviction.
        do_txn(1'b1, 32'h0000_0010, {4{32'hBBBB_BBBB}}, "t2_wb");
        do_txn(1'b0, 32'h0000_1010, '0, "t2_evict");

        // Processor ID bits do not take part in the tag.
        do_txn(1'b0, 32'h4000_1010, '0, "t3_pid_hit");
        do_txn(1'b0, 32'h0000_0010, '0, "t3_refill");
        do_txn(1'b0, 32'h4000_0010, '0, "t3_pid_hit2");

        // Simultaneous requests: write-back first, read stays pending.
        bus_if.l1_addr    = 32'h0000_0020;
        bus_if.l1_wb_data = {4{32'hDDDD_0020}};
        bus_if.l1_wb_req  = 1'b1;
        bus_if.l1_rd_req  = 1'b1;
        serve(1'b1, 32'h0000_0020, {4{32'hDDDD_0020}}, 0, "t4_wb");
        bus_if.l1_wb_req = 1'b0;
        serve(1'b0, 32'h0000_0020, '0, 1, "t4_rd");
        bus_if.l1_rd_req = 1'b0;
        @(posedge clk);
        #1;

        // Reset while a fill is outstanding.
        fixed_delay = 20;
        bus_if.l1_addr   = 32'h0000_3010;
        bus_if.l1_rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.mem_rd_req) break;
        end
        check("t5_rdreq_pending", 128'(bus_if.mem_rd_req), 128'(1));
        reset = 1'b1;
        #1;
        check_outputs_zero("t5_reset");
        bus_if.l1_rd_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        fixed_delay = -1;
        do_txn(1'b0, 32'h0000_0010, '0, "t5_after");

        // Random traffic over a few conflicting tags and indices.
        for (int n = 0; n < 80; n++) begin
            addr = (32'($urandom_range(0, 3)) << 30) | (32'($urandom_range(0, 2)) << 8) |
                   (32'($urandom_range(4, 7)) << 2) | 32'($urandom_range(0, 3));
            data = {$urandom, $urandom, $urandom, $urandom};
            do_txn(1'($urandom_range(0, 1)), addr, data, "rnd");
        end

        check("exclusive_pulses", 128'(n_viol), 128'(0));
`ifdef L2_CACHE_STATS_EN
        check("stat_hits", 128'(stat_hits), 128'(exp_hits));
        check("stat_misses", 128'(stat_misses), 128'(exp_misses));
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
